// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues word reads to instr_mem and queues returned
// instructions with their PC for decode; execute redirects flush wrong-path work.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        misalign_err
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic          pop;
    logic          push;
    logic          issue;
    logic [AW+1:0] occupancy;

    assign id_valid  = count != '0;
    assign id_instr  = fifo_instr[rd_ptr];
    assign id_pc     = fifo_pc[rd_ptr];
    assign pop       = id_valid & id_ready;
    assign push      = inflight & ~redirect_valid;
    // Counting the in-flight word as occupied guarantees its capture always finds room.
    assign occupancy = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);
    assign issue     = ~redirect_valid & (occupancy < (AW+2)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            imem_rd_en   <= 1'b0;
            imem_addr    <= {2'b00, RESET_PC[31:2]};
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            pc           <= {redirect_pc[31:2], 2'b00};
            imem_rd_en   <= 1'b0;
            inflight     <= 1'b0;
            count        <= '0;
            rd_ptr       <= wr_ptr;
            misalign_err <= misalign_err | (redirect_pc[1:0] != 2'b00);
        end else begin
            imem_rd_en <= issue;
            inflight   <= issue;
            if (issue) begin
                imem_addr   <= {2'b00, pc[31:2]};
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr[wr_ptr] <= imem_instr;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: instr_mem model plus a stream-level scoreboard: decode must see
// consecutive PCs from the last redirect target (or reset PC), each with mem[pc>>2].
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        misalign_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          stall = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        exp_mis = 1'b0;
    logic [31:0] head;
    logic [31:0] t;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // Memory answers on negedge; when idle it returns junk the fetch unit must ignore.
    always @(negedge clk) imem_instr = imem_rd_en ? mem_word(imem_addr) : $urandom();

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        if (redirect_valid) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
        end else if (id_valid && id_ready) begin
            check("deliver_pc", id_pc, exp_pc);
            check("deliver_instr", id_instr, mem_word(exp_pc >> 2));
            exp_pc += 32'd4;
            pops++;
        end
        @(posedge clk);
        #1;
        check("misalign_err", misalign_err, exp_mis);
        check("no_overflow", dut.count <= DEPTH, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, id_valid, 0);
        check({tag, "_instr"}, id_instr, 0);
        check({tag, "_pc"}, id_pc, 0);
        check({tag, "_rd_en"}, imem_rd_en, 0);
        check({tag, "_addr"}, imem_addr, RESET_PC >> 2);
        check({tag, "_mis"}, misalign_err, 0);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid_drop", id_valid, 0);
        check("redir_rd_en_drop", imem_rd_en, 0);
        tick();
        check("redir_issue", imem_rd_en, 1);
        check("redir_addr", imem_addr, {2'b00, target[31:2]});
        check("redir_empty", id_valid, 0);
        tick();
        check("redir_valid", id_valid, 1);
        check("redir_pc", id_pc, {target[31:2], 2'b00});
        check("redir_instr", id_instr, mem_word({2'b00, target[31:2]}));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        id_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("first_issue", imem_rd_en, 1);
        check("first_addr", imem_addr, 0);
        check("first_not_valid", id_valid, 0);
        for (int k = 2; k < 8; k++) begin
            tick();
            check("stream_valid", id_valid, 1);
            check("stream_addr", imem_addr, k - 1);
        end
        id_ready = 1'b0;
        head = id_pc;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_head", id_pc, head);
        end
        check("bp_valid", id_valid, 1);
        check("bp_rd_en", imem_rd_en, 0);
        id_ready = 1'b1;
        repeat (6) tick();
        redirect(32'h40);
        repeat (3) tick();
        redirect(32'h42);
        repeat (2) tick();
        check("mis_sticky", misalign_err, 1);
        redirect(32'h100);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_addr0", imem_addr, 32'h3FFF_FFFE);
        tick();
        check("wrap_addr1", imem_addr, 32'h3FFF_FFFF);
        check("wrap_pc0", id_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr2", imem_addr, 32'h0000_0000);
        check("wrap_pc1", id_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc2", id_pc, 32'h0000_0000);
        id_ready = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        exp_pc = RESET_PC;
        exp_mis = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        tick();
        tick();
        check("rerst_valid", id_valid, 1);
        check("rerst_pc", id_pc, RESET_PC);
        for (int c = 0; c < 3000; c++) begin
            id_ready = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 15) == 0;
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255)
                                              : $urandom_range(0, 4095);
            if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
            redirect_pc = t;
            tick();
            stall = (redirect_valid || id_valid) ? 0 : stall + 1;
            check("stall_bound", stall <= 2, 1);
        end
        redirect_valid = 1'b0;
        check("pop_count", pops > 1000, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
